// File: rtl/w_icons_mgmt_pkg.sv
// Shared types for the icons clock-generator block.
package w_icons_mgmt_pkg;

  // Per-channel divider state; encodings are shared with software-visible status.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ch_state_e;

  localparam int MAX_CH = 16;

endpackage

// File: rtl/w_icons_clkgen_multi_if.sv
// Control/status bundle for the multi-channel clock generator.
interface w_icons_clkgen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 12
);
  logic [NUM_CH-1:0]       enable_i;
  logic [NUM_CH*DIV_W-1:0] div_val_i;
  logic                    sync_start_i;
  logic [NUM_CH-1:0]       clk_div_o;
  logic [NUM_CH-1:0]       rise_o;
  logic [NUM_CH-1:0]       active_o;

  modport master (
    output enable_i, div_val_i, sync_start_i,
    input  clk_div_o, rise_o, active_o
  );

  modport slave (
    input  enable_i, div_val_i, sync_start_i,
    output clk_div_o, rise_o, active_o
  );
endinterface

// File: rtl/w_icons_clkgen_ch.sv
// One divided-clock channel: IDLE -> HIGH (shadow cycles) -> LOW (shadow cycles).
// The divide value is captured into a shadow only at start, at the period
// boundary or on sync, so mid-period changes never glitch the output.
module w_icons_clkgen_ch
  import w_icons_mgmt_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] div_val_i,
  input  logic             sync_start_i,
  output logic             clk_div_o,
  output logic             rise_o,
  output logic             active_o
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             start_ok;
  logic             last;
  logic             load;

  // Next state: a load (start, boundary reload or sync) always wins and is the
  // only source of a rising edge, so sync on a boundary yields one pulse.
  always_comb begin
    start_ok = enable_i && (div_val_i != '0);
    last     = (cnt_q == shadow_q - DIV_W'(1));
    load     = start_ok && (sync_start_i || (state_q == ST_IDLE) ||
                            ((state_q == ST_LOW) && last));
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (load) begin
      state_d  = ST_HIGH;
      cnt_d    = '0;
      shadow_d = div_val_i;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_HIGH: begin
          if (last) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        ST_LOW: begin
          if (last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State/counters plus outputs registered from the next state so every output is a flop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      clk_div_o <= 1'b0;
      rise_o    <= 1'b0;
      active_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      clk_div_o <= (state_d == ST_HIGH);
      rise_o    <= load;
      active_o  <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: rtl/w_icons_clkgen_multi.sv
// NUM_CH independent 50%-duty clock dividers sharing one sync_start pulse.
module w_icons_clkgen_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 12
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  w_icons_clkgen_multi_if.slave bus
);

  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] active;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    w_icons_clkgen_ch #(.DIV_W(DIV_W)) u_ch (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .enable_i     (bus.enable_i[k]),
      .div_val_i    (bus.div_val_i[k*DIV_W +: DIV_W]),
      .sync_start_i (bus.sync_start_i),
      .clk_div_o    (clk_div[k]),
      .rise_o       (rise[k]),
      .active_o     (active[k])
    );
  end

  assign bus.clk_div_o = clk_div;
  assign bus.rise_o    = rise;
  assign bus.active_o  = active;

endmodule

// File: tb/tb_w_icons_clkgen_multi.sv
// Bench: expected rise cycles are queued when stimulus is applied and matched
// against every observed rise_o pulse; waveform/active levels spot-checked.
module tb_w_icons_clkgen_multi;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  typedef struct {int ch; int cyc;} exp_t;
  exp_t sb[$];

  w_icons_clkgen_multi_if #(.NUM_CH(4), .DIV_W(12)) a_if();
  w_icons_clkgen_multi_if #(.NUM_CH(2), .DIV_W(4))  b_if();

  w_icons_clkgen_multi #(.NUM_CH(4), .DIV_W(12)) u_a (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(a_if));
  w_icons_clkgen_multi #(.NUM_CH(2), .DIV_W(4)) u_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(b_if));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [5:0] rise_all;
  assign rise_all = {b_if.rise_o, a_if.rise_o};

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic push(int ch, int c);
    exp_t e;
    e.ch  = ch;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic at(int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // every rise must match the oldest queued expectation for that channel
  always @(negedge clk_i) begin
    for (int k = 0; k < 6; k++) begin
      if (rise_all[k]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].ch == k) idx = i;
        if (idx < 0) chk($sformatf("rise_unexp_ch%0d", k), cyc, -1);
        else begin
          chk($sformatf("rise_ch%0d", k), cyc, sb[idx].cyc);
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    a_if.enable_i = '0; a_if.div_val_i = '0; a_if.sync_start_i = 1'b0;
    b_if.enable_i = '0; b_if.div_val_i = '0; b_if.sync_start_i = 1'b0;
    a_if.enable_i[3] = 1'b1;   // div 0: must never leave IDLE
    b_if.enable_i[1] = 1'b1;   // div 0 on the 4-bit instance too

    at(1);
    chk("rst_clk_a", int'(a_if.clk_div_o), 0);
    chk("rst_rise_a", int'(a_if.rise_o), 0);
    chk("rst_act_a", int'(a_if.active_o), 0);
    chk("rst_clk_b", int'(b_if.clk_div_o), 0);
    at(2); reset_n_i = 1'b1;
    at(5); chk("div0_idle", int'(a_if.active_o), 0);

    // ch0 div=3 from cycle 10
    at(10);
    a_if.div_val_i[0 +: 12] = 12'd3; a_if.enable_i[0] = 1'b1;
    push(0, 11); push(0, 17); push(0, 23);
    chk("c0_pre", a_if.clk_div_o[0], 0);
    at(11); chk("c0_h11", a_if.clk_div_o[0], 1);
    at(13); chk("c0_h13", a_if.clk_div_o[0], 1);
    at(14); chk("c0_l14", a_if.clk_div_o[0], 0);
    at(16); chk("c0_l16", a_if.clk_div_o[0], 0);
    at(17); chk("c0_h17", a_if.clk_div_o[0], 1);
    at(23); a_if.enable_i[0] = 1'b0;
    at(28); chk("c0_act28", a_if.active_o[0], 1);
    at(29); chk("c0_act29", a_if.active_o[0], 0);

    // ch1 div=4, changed to 2 mid-HIGH
    at(40);
    a_if.div_val_i[12 +: 12] = 12'd4; a_if.enable_i[1] = 1'b1;
    push(1, 41); push(1, 49); push(1, 53);
    at(42); a_if.div_val_i[12 +: 12] = 12'd2;
    at(44); chk("c1_h44", a_if.clk_div_o[1], 1);
    at(45); chk("c1_l45", a_if.clk_div_o[1], 0);
    at(48); chk("c1_l48", a_if.clk_div_o[1], 0);
    at(49); chk("c1_h49", a_if.clk_div_o[1], 1);
    at(50); chk("c1_h50", a_if.clk_div_o[1], 1);
    at(51); chk("c1_l51", a_if.clk_div_o[1], 0);
    at(53); a_if.enable_i[1] = 1'b0;
    at(56); chk("c1_act56", a_if.active_o[1], 1);
    at(57); chk("c1_act57", a_if.active_o[1], 0);

    // ch2 div=5, enable dropped in 2nd HIGH cycle
    at(70);
    a_if.div_val_i[24 +: 12] = 12'd5; a_if.enable_i[2] = 1'b1;
    push(2, 71);
    at(72); a_if.enable_i[2] = 1'b0;
    at(75); chk("c2_h75", a_if.clk_div_o[2], 1);
    at(76); chk("c2_l76", a_if.clk_div_o[2], 0);
    at(80); chk("c2_act80", a_if.active_o[2], 1);
    at(81); chk("c2_act81", a_if.active_o[2], 0);

    // sync: ch0 div=3 and ch1 div=7; second sync lands on ch0's boundary
    at(100);
    a_if.div_val_i[0 +: 12] = 12'd3; a_if.div_val_i[12 +: 12] = 12'd7;
    a_if.enable_i[1:0] = 2'b11;
    push(0, 101); push(0, 107); push(0, 111); push(0, 117); push(0, 123);
    push(1, 101); push(1, 111); push(1, 117);
    at(110);
    chk("s_c0_110", a_if.clk_div_o[0], 0);
    chk("s_c1_110", a_if.clk_div_o[1], 0);
    a_if.sync_start_i = 1'b1;
    at(111);
    a_if.sync_start_i = 1'b0;
    chk("s_c0_111", a_if.clk_div_o[0], 1);
    chk("s_c1_111", a_if.clk_div_o[1], 1);
    chk("s_c3_idle", a_if.active_o[3], 0);
    at(116);
    chk("s_c0_116", a_if.clk_div_o[0], 0);
    chk("s_c1_116", a_if.clk_div_o[1], 1);
    a_if.sync_start_i = 1'b1;
    at(117);
    a_if.sync_start_i = 1'b0;
    chk("s_c0_117", a_if.clk_div_o[0], 1);
    chk("s_c1_117", a_if.clk_div_o[1], 1);
    at(124); a_if.enable_i[1:0] = 2'b00;
    at(128); chk("s_c0_act128", a_if.active_o[0], 1);
    at(129); chk("s_c0_act129", a_if.active_o[0], 0);
    at(130); chk("s_c1_act130", a_if.active_o[1], 1);
    at(131); chk("s_c1_act131", a_if.active_o[1], 0);

    // reset mid-HIGH on ch2, enable held through release
    at(150);
    a_if.div_val_i[24 +: 12] = 12'd6; a_if.enable_i[2] = 1'b1;
    push(2, 151); push(2, 156);
    at(153);
    chk("r_c2_pre", a_if.clk_div_o[2], 1);
    reset_n_i = 1'b0;
    #1;
    chk("r_c2_clk", a_if.clk_div_o[2], 0);
    chk("r_c2_act", a_if.active_o[2], 0);
    at(155);
    reset_n_i = 1'b1;
    chk("r_c2_rel", a_if.clk_div_o[2], 0);
    at(156); chk("r_c2_h156", a_if.clk_div_o[2], 1);
    at(157); a_if.enable_i[2] = 1'b0;
    at(167); chk("r_c2_act167", a_if.active_o[2], 1);
    at(168); chk("r_c2_act168", a_if.active_o[2], 0);

    // DIV_W=4 instance: div=15 (max) gives a 30-cycle period
    at(200);
    b_if.div_val_i[0 +: 4] = 4'd15; b_if.enable_i[0] = 1'b1;
    push(4, 201); push(4, 231); push(4, 261);
    at(215); chk("b_h215", b_if.clk_div_o[0], 1);
    at(216); chk("b_l216", b_if.clk_div_o[0], 0);
    at(230); chk("b_l230", b_if.clk_div_o[0], 0);
    at(231); chk("b_h231", b_if.clk_div_o[0], 1);
    at(250); chk("b_div0_idle", b_if.active_o[1], 0);
    at(261); b_if.enable_i[0] = 1'b0;
    at(290); chk("b_act290", b_if.active_o[0], 1);
    at(291); chk("b_act291", b_if.active_o[0], 0);

    at(300);
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/w_icons_clkgen_multi.md
W_ICONS_CLKGEN_MULTI -- requirements
Module: w_icons_clkgen_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 12, width of each per-channel half-period divide value.
REQ-003 SHALL have one clock and an asynchronous active-low reset; port clk_i, input, 1, reference clock (sole clock domain).
REQ-004 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable_i, input, NUM_CH, per-channel run enable, synchronous to clk_i.
REQ-006 SHALL have port div_val_i, input, NUM_CH*DIV_W, packed half-period values; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-007 SHALL have port sync_start_i, input, 1, single-cycle pulse that phase-aligns all running channels.
REQ-008 SHALL have port clk_div_o, output, NUM_CH, registered divided clocks.
REQ-009 SHALL have port rise_o, output, NUM_CH, one-cycle pulse coincident with each clk_div_o rising edge.
REQ-010 SHALL have port active_o, output, NUM_CH, high while a channel is in HIGH or LOW state.

Function
REQ-011 SHALL implement per channel a three-state FSM: IDLE, HIGH, LOW, with a DIV_W-bit cycle counter and a DIV_W-bit shadow divide register.
REQ-012 In IDLE, clk_div_o=0, rise_o=0, active_o=0; when enable_i=1 and div_val_i!=0, SHALL load shadow from div_val_i, clear counter, enter HIGH next cycle (latency 1 cycle).
REQ-013 HIGH SHALL last exactly shadow cycles with clk_div_o=1; rise_o=1 only in the first HIGH cycle.
REQ-014 LOW SHALL last exactly shadow cycles with clk_div_o=0; output period = 2*shadow clk_i cycles, 50% duty.
REQ-015 At the last LOW cycle: if enable_i=1 and div_val_i!=0, SHALL reload shadow from div_val_i and enter HIGH; otherwise enter IDLE.
REQ-016 Changes of div_val_i during HIGH/LOW SHALL be ignored until the period boundary (glitch-free update).
REQ-017 enable_i deasserted during HIGH or LOW SHALL NOT truncate the period; the channel completes LOW then goes IDLE.
REQ-018 div_val_i=0 at the start condition or boundary SHALL hold/return the channel to IDLE.
REQ-019 sync_start_i=1 SHALL, for every channel with enable_i=1 and div_val_i!=0 (any state), reload shadow, clear counter, and enter HIGH next cycle with rise_o=1 (may truncate a running pulse by design).
REQ-020 sync_start_i coincident with a natural boundary SHALL yield a single rise_o pulse, not two.
REQ-021 Counters SHALL compare against shadow-1 and never wrap; shadow=2^DIV_W-1 SHALL be supported.
REQ-022 Channels SHALL be fully independent except for the shared sync_start_i.

Reset
REQ-023 On reset_n_i=0 all FSMs SHALL enter IDLE asynchronously; clk_div_o, rise_o, active_o, counters and shadows SHALL be 0.
REQ-024 After reset release, no channel SHALL start before the first clk_i edge sampling enable_i=1.
REQ-025 Reset asserted mid-period SHALL force clk_div_o low immediately with no further pulses.

Structure
REQ-026 FSM state encodings (IDLE=2'd0, HIGH=2'd1, LOW=2'd2) SHALL live in shared package w_icons_mgmt_pkg.
REQ-027 Per-channel logic SHALL be sub-module w_icons_clkgen_ch, instantiated NUM_CH times via generate.
REQ-028 All outputs SHALL be driven directly from flops (no combinational path input-to-output).

Verification
REQ-029 Ch0 div=3, enable at cycle 10 -> clk_div_o[0] high cycles 11-13, low 14-16, rise_o at 11, 17, 23.
REQ-030 Ch1 div=4 running, div_val changed to 2 mid-HIGH -> current period stays 8 cycles, next period 4 cycles, no glitch.
REQ-031 Ch2 div=5, enable dropped in 2nd HIGH cycle -> HIGH completes 5, LOW 5, then IDLE, active_o falls after last LOW cycle.
REQ-032 Ch0 div=3, ch1 div=7 running, sync_start pulse -> both rise_o asserted same next cycle, subsequent edges aligned per own period.
REQ-033 DIV_W=4, div=15 and div=0 -> period 30 cycles; div=0 never leaves IDLE.
REQ-034 reset_n_i low mid-HIGH -> clk_div_o=0 immediately; after release with enable held, restart latency exactly 1 cycle.
